// File: rtl/isr_pipe.sv
// Iterative restoring integer square root that resolves BITS_PER_CYCLE root bits per falling edge. Result after N = WIDTH/(2*BITS_PER_CYCLE) edges.
// start is accepted only in IDLE/DONE (ignored while busy). Defining ISR_ROUND_EN makes result round to nearest; remainder stays the floor remainder.
module isr_pipe #(
  parameter int WIDTH          = 64,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   value,
  output logic               busy,
  output logic               done,
  output logic [WIDTH/2-1:0] result,
  output logic [WIDTH/2:0]   remainder
);

  localparam int H  = WIDTH / 2;
  localparam int N  = H / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] rad, rad_nx;
  logic [H-1:0]     root, root_nx;
  logic [H+1:0]     rem, rem_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic             busy_nx, done_nx;
  logic [H-1:0]     result_nx;
  logic [H:0]       remainder_nx;

  logic [WIDTH-1:0] s_rad;
  logic [H-1:0]     s_root;
  logic [H+1:0]     s_rem, s_trial;
  logic [H-1:0]     rnd_root;

  // Unrolled restoring steps; radicand is shifted left so the next pair is always at the top.
  always_comb begin
    s_rad   = rad;
    s_root  = root;
    s_rem   = rem;
    s_trial = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      s_rem   = {s_rem[H-1:0], s_rad[WIDTH-1 -: 2]};
      s_trial = {s_root, 2'b01};
      if (s_rem >= s_trial) begin
        s_rem  = s_rem - s_trial;
        s_root = {s_root[H-2:0], 1'b1};
      end else begin
        s_root = {s_root[H-2:0], 1'b0};
      end
      s_rad = {s_rad[WIDTH-3:0], 2'b00};
    end
  end

`ifdef ISR_ROUND_EN
  assign rnd_root = ((s_rem > {2'b00, s_root}) && !(&s_root)) ? s_root + H'(1) : s_root;
`else
  assign rnd_root = s_root;
`endif

  always_comb begin
    state_nx     = state;
    rad_nx       = rad;
    root_nx      = root;
    rem_nx       = rem;
    cnt_nx       = cnt;
    busy_nx      = busy;
    done_nx      = done;
    result_nx    = result;
    remainder_nx = remainder;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          rad_nx   = value;
          root_nx  = '0;
          rem_nx   = '0;
          cnt_nx   = CW'(N);
          busy_nx  = 1'b1;
          done_nx  = 1'b0;
          state_nx = CALC;
        end
      end
      CALC: begin
        rad_nx  = s_rad;
        root_nx = s_root;
        rem_nx  = s_rem;
        cnt_nx  = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          result_nx    = rnd_root;
          remainder_nx = s_rem[H:0];
          busy_nx      = 1'b0;
          done_nx      = 1'b1;
          state_nx     = DONE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(negedge clock) begin
    if (reset) begin
      state     <= IDLE;
      rad       <= '0;
      root      <= '0;
      rem       <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      remainder <= '0;
    end else begin
      state     <= state_nx;
      rad       <= rad_nx;
      root      <= root_nx;
      rem       <= rem_nx;
      cnt       <= cnt_nx;
      busy      <= busy_nx;
      done      <= done_nx;
      result    <= result_nx;
      remainder <= remainder_nx;
    end
  end

endmodule
